// File: rtl/bram_stream_reader.sv
// Burst reader for a 1-cycle-latency block RAM, streaming words out through a 2-entry skid buffer.
// Optional build macro BRAM_STREAM_READER_LAST_EN adds an o_last end-of-burst marker on the stream.
module bram_stream_reader #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 65536,
   localparam int AW         = $clog2(DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [LW-1:0]         length,
   output logic                  busy,
   output logic                  done,
   output logic [AW-1:0]         rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
`ifdef BRAM_STREAM_READER_LAST_EN
   output logic                  o_last,
`endif
   input  logic                  o_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [AW-1:0]           r_addr;
   logic [LW-1:0]           r_remain;
   logic                    r_inflight;
   logic                    r_inflight_last;
   logic [1:0]              r_count;
   logic                    r_wr_ptr;
   logic                    r_rd_ptr;
   logic [1:0]              w_occ;
   logic                    w_issue;
   logic                    w_push;
   logic                    w_pop;
   logic [AW-1:0]           w_addr_inc;
   logic [DATA_WIDTH-1:0]   w_head_data;
   logic                    w_head_last;

   // Occupancy counts the in-flight word too, so the skid buffer can never be overrun.
   assign w_occ      = r_count + {1'b0, r_inflight};
   assign w_push     = r_inflight;
   assign w_pop      = (r_count != 2'd0) && o_ready;
   assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (length == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            w_issue = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
            if (w_issue && (r_remain == LW'(1))) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_inflight && (r_count == 2'd0)) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_addr          <= '0;
         r_remain        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_remain == LW'(1));
         if ((r_state == S_IDLE) && start) begin
            r_addr   <= base_addr;
            r_remain <= length;
         end else if (w_issue) begin
            r_addr   <= w_addr_inc;
            r_remain <= r_remain - 1'b1;
         end
      end
   end

   // Skid buffer pointers and fill level; a push and pop in one cycle leave the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi = gi + 1) begin : g_entry
         logic [DATA_WIDTH-1:0] r_word;
         logic                  r_last;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_word <= '0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
               r_word <= rd_data;
            end
         end
`ifdef BRAM_STREAM_READER_LAST_EN
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_last <= 1'b0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
               r_last <= r_inflight_last;
            end
         end
`else
         assign r_last = 1'b0;
`endif
      end
   endgenerate

   assign w_head_data = r_rd_ptr ? g_entry[1].r_word : g_entry[0].r_word;
   assign w_head_last = r_rd_ptr ? g_entry[1].r_last : g_entry[0].r_last;

   assign o_data  = w_head_data;
   assign o_valid = (r_count != 2'd0);
`ifdef BRAM_STREAM_READER_LAST_EN
   assign o_last  = o_valid && w_head_last;
`else
   logic w_unused_last;
   assign w_unused_last = w_head_last ^ r_inflight_last;
`endif
   assign rd_en   = w_issue;
   assign rd_addr = r_addr;
   assign busy    = (r_state == S_READ) || (r_state == S_DRAIN);
   assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Table-driven bench for bram_stream_reader: bursts with several o_ready patterns, plus reset-abort.
// Cycle index k counts edges after the edge that samples start (k=0 is the cycle right after it).
module tb_bram_stream_reader;

   localparam int DW = 32;
   localparam int DEPTH = 65536;
   localparam int AW = 16;
   localparam int LW = 17;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] length;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_ready;
`ifdef BRAM_STREAM_READER_LAST_EN
   logic          o_last;
`endif

   int total_checks = 0;
   int passed_checks = 0;

   bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .o_data    (o_data),
      .o_valid   (o_valid),
`ifdef BRAM_STREAM_READER_LAST_EN
      .o_last    (o_last),
`endif
      .o_ready   (o_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   // RAM model: registered read, one cycle latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram_word(rd_addr);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total_checks++;
      if (act == exp) passed_checks++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      int            mode;       // 0: ready=1, 1: ready 1,0,0,1,0,1..., 2: ready=0 for 6 cycles
      int            exp_first;  // -1: not checked
      int            exp_done;   // -1: not checked
      bit            poke;       // extra start pulse at k=0 (must be ignored)
   } vec_t;

   function automatic logic ready_of(input int mode, input int k);
      logic [5:0] pat;
      pat = 6'b101001;
      case (mode)
         0:       return 1'b1;
         1:       return pat[k % 6];
         default: return (k >= 6);
      endcase
   endfunction

   task automatic run_burst(input vec_t v);
      int k, done_k, first_k, nwords, issues, outst;
      int addr_bad, occ_bad, stall_bad, busy_bad, last_bad, idle_bad;
      logic pop, prev_stall;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] got[64];
      k = 0; done_k = -1; first_k = -1; nwords = 0; issues = 0; outst = 0;
      addr_bad = 0; occ_bad = 0; stall_bad = 0; busy_bad = 0; last_bad = 0; idle_bad = 0;
      prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      start = 1'b1; base_addr = v.base; length = v.len; o_ready = 1'b1;
      @(negedge clk);
      while (k < 80 && done_k < 0) begin
         start = 1'b0;
         if (v.poke && k == 0) begin
            start = 1'b1; base_addr = 16'h0300; length = 17'd9;
         end
         o_ready = ready_of(v.mode, k);
         #1;
         pop = o_valid && o_ready;
         if (o_valid && first_k < 0) first_k = k;
         if (prev_stall && (!o_valid || o_data !== prev_data)) stall_bad++;
         if (pop) begin
`ifdef BRAM_STREAM_READER_LAST_EN
            if (o_last !== (nwords == int'(v.len) - 1)) last_bad++;
`endif
            if (nwords < 64) got[nwords] = o_data;
            nwords++;
         end
         if (rd_en) begin
            if (rd_addr !== AW'(v.base + AW'(issues))) addr_bad++;
            if (outst >= 2 && !pop) occ_bad++;
            issues++;
         end
         outst = outst + (rd_en ? 1 : 0) - (pop ? 1 : 0);
         if (done) begin
            done_k = k;
            if (busy) busy_bad++;
         end else if (!busy) busy_bad++;
         prev_stall = o_valid && !o_ready;
         prev_data = o_data;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         if (busy || done || rd_en || o_valid) idle_bad++;
         @(negedge clk);
      end
      $display("burst base=%h len=%0d mode=%0d words=%0d first_k=%0d done_k=%0d",
               v.base, v.len, v.mode, nwords, first_k, done_k);
      chk("done_seen", longint'(done_k >= 0), 1);
      if (v.exp_done >= 0) chk("done_cycle", done_k, v.exp_done);
      if (v.exp_first >= 0) chk("first_valid_cycle", first_k, v.exp_first);
      chk("read_count", issues, longint'(v.len));
      chk("word_count", nwords, longint'(v.len));
      for (int i = 0; i < nwords && i < int'(v.len) && i < 64; i++)
         chk($sformatf("word%0d", i), got[i], ram_word(AW'(v.base + AW'(i))));
      chk("rd_addr_sequence_errors", addr_bad, 0);
      chk("issue_without_room", occ_bad, 0);
      chk("stall_unstable", stall_bad, 0);
      chk("busy_errors", busy_bad, 0);
      chk("idle_after_done_errors", idle_bad, 0);
`ifdef BRAM_STREAM_READER_LAST_EN
      chk("o_last_errors", last_bad, 0);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_o_valid"}, o_valid, 0);
      chk({tag, "_o_data"}, o_data, 0);
`ifdef BRAM_STREAM_READER_LAST_EN
      chk({tag, "_o_last"}, o_last, 0);
`endif
   endtask

   vec_t vecs[7];
   vec_t post;

   initial begin
      // Expected values: first word at k=2, done at k=len+3; len=0 gives done right after start.
      vecs[0] = '{16'h0010, 17'd4, 0,  2,  7, 1'b0};
      vecs[1] = '{16'h0010, 17'd4, 1,  2, -1, 1'b0};
      vecs[2] = '{16'hFFFE, 17'd4, 0,  2,  7, 1'b0};
      vecs[3] = '{16'h0020, 17'd0, 0, -1,  0, 1'b1};
      vecs[4] = '{16'h0030, 17'd3, 2, -1, -1, 1'b0};
      vecs[5] = '{16'h0055, 17'd1, 0,  2,  4, 1'b0};
      vecs[6] = '{16'h0200, 17'd6, 1,  2, -1, 1'b1};

      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; o_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_burst(vecs[i]);

      // Abort mid-burst: one word buffered and one read in flight when reset hits.
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0040; length = 17'd8; o_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("pre_reset_valid", o_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset abort of burst base=0040 len=8");

      post = '{16'h0080, 17'd2, 0, 2, 5, 1'b0};
      run_burst(post);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
